// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone burst master.
//   CTI_*   : cycle type identifier codes driven on cti_o
//   state_e : burst master FSM states
package wb_master_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUS = 2'd1,
        XFER     = 2'd2,
        DONE0    = 2'd3
    } state_e;

endpackage

// File: rtl/wb_wait_timer.sv
// Down-counting wait timer shared by the bus-free wait and the per-word stall.
//   clk_i, rst_ni : clock, async active-low reset
//   load          : reload the counter with MAX_WAIT
//   dec           : decrement (saturates at zero)
//   expired       : counter has reached zero
module wb_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(MAX_WAIT);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/wishbone_burst_master.sv
// Wishbone B4 classic burst master moving up to MAX_PAYLOAD words between a
// flat payload vector and a slave.
//   Wishbone side : adr_o, dat_i, dat_o, we_o, sel_o, stb_o, cyc_o, cyc_i,
//                   ack_i, err_i, cti_o
//   Local side    : transfer_address, payload_in/out, payload_length,
//                   byte_enable, start_read, start_write, abort
//   Status        : busy, completed, timeout, error (sticky), words_done
//
// state    | meaning
// IDLE     | no burst; start_read/start_write accepted here
// WAIT_BUS | waiting for another master to release the bus (cyc_i low)
// XFER     | driving cyc/stb for the word at offset words_done
// DONE0    | zero-length request; flag completion and return to IDLE
module wishbone_burst_master
    import wb_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int SEL_WIDTH     = DATA_WIDTH / 8,
    parameter int MAX_PAYLOAD   = 8,
    parameter int ADDR_STEP     = 1,
    parameter int MAX_WAIT      = 15,
    parameter int LEN_W         = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    output logic [ADDRESS_WIDTH-1:0]          adr_o,
    input  logic [DATA_WIDTH-1:0]             dat_i,
    output logic [DATA_WIDTH-1:0]             dat_o,
    output logic                              we_o,
    output logic [SEL_WIDTH-1:0]              sel_o,
    output logic                              stb_o,
    output logic                              cyc_o,
    input  logic                              cyc_i,
    input  logic                              ack_i,
    input  logic                              err_i,
    output logic [2:0]                        cti_o,
    input  logic [ADDRESS_WIDTH-1:0]          transfer_address,
    input  logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_in,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_out,
    input  logic [LEN_W-1:0]                  payload_length,
    input  logic [SEL_WIDTH-1:0]              byte_enable,
    input  logic                              start_read,
    input  logic                              start_write,
    input  logic                              abort,
    output logic                              busy,
    output logic                              completed,
    output logic                              timeout,
    output logic                              error,
    output logic [LEN_W-1:0]                  words_done
);

    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [LEN_W-1:0]         MAX_LEN = LEN_W'(MAX_PAYLOAD);
    localparam logic [ADDRESS_WIDTH-1:0] STEP    = ADDRESS_WIDTH'(ADDR_STEP);

    state_e                     state_q, state_d;
    logic                       is_read_q, is_read_d;
    logic [ADDRESS_WIDTH-1:0]   base_q, base_d;
    logic [SEL_WIDTH-1:0]       sel_q, sel_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           words_q, words_d;
    logic [DATA_WIDTH-1:0]      wr_word_q [MAX_PAYLOAD];
    logic [DATA_WIDTH-1:0]      wr_word_d [MAX_PAYLOAD];
    logic [DATA_WIDTH-1:0]      rd_word_q [MAX_PAYLOAD];
    logic [DATA_WIDTH-1:0]      rd_word_d [MAX_PAYLOAD];
    logic                       completed_q, completed_d;
    logic                       timeout_q, timeout_d;
    logic                       error_q, error_d;

    logic                       tmr_load, tmr_dec, tmr_expired;
    logic [IDX_W-1:0]           idx;
    logic                       last_word;

    // words_done doubles as the word offset inside the burst.
    assign idx       = words_q[IDX_W-1:0];
    assign last_word = (words_q == (len_q - 1'b1));

    wb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        base_d      = base_q;
        sel_d       = sel_q;
        len_d       = len_q;
        words_d     = words_q;
        wr_word_d   = wr_word_q;
        rd_word_d   = rd_word_q;
        completed_d = completed_q;
        timeout_d   = timeout_q;
        error_d     = error_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_read || start_write) begin
                    is_read_d   = start_read;
                    base_d      = transfer_address;
                    sel_d       = byte_enable;
                    len_d       = (payload_length > MAX_LEN) ? MAX_LEN : payload_length;
                    for (int k = 0; k < MAX_PAYLOAD; k++) begin
                        wr_word_d[k] = payload_in[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                    completed_d = 1'b0;
                    timeout_d   = 1'b0;
                    error_d     = 1'b0;
                    words_d     = '0;
                    tmr_load    = 1'b1;
                    state_d     = (payload_length == '0) ? DONE0 : WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                if (!cyc_i) begin
                    tmr_load = 1'b1;
                    state_d  = XFER;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            XFER: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (err_i) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (ack_i) begin
                    if (is_read_q) begin
                        rd_word_d[idx] = dat_i;
                    end
                    words_d  = words_q + 1'b1;
                    tmr_load = 1'b1;
                    if (last_word) begin
                        completed_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE0: begin
                completed_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            is_read_q   <= 1'b0;
            base_q      <= '0;
            sel_q       <= '0;
            len_q       <= '0;
            words_q     <= '0;
            wr_word_q   <= '{default: '0};
            rd_word_q   <= '{default: '0};
            completed_q <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            base_q      <= base_d;
            sel_q       <= sel_d;
            len_q       <= len_d;
            words_q     <= words_d;
            wr_word_q   <= wr_word_d;
            rd_word_q   <= rd_word_d;
            completed_q <= completed_d;
            timeout_q   <= timeout_d;
            error_q     <= error_d;
        end
    end

    // Bus outputs depend only on registered state, so an async reset drops
    // cyc_o/stb_o immediately.
    always_comb begin
        cyc_o = 1'b0;
        stb_o = 1'b0;
        we_o  = 1'b0;
        adr_o = '0;
        sel_o = '0;
        dat_o = '0;
        cti_o = CTI_CLASSIC;
        if (state_q == XFER) begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
            we_o  = !is_read_q;
            adr_o = base_q + (ADDRESS_WIDTH'(words_q) * STEP);
            sel_o = sel_q;
            if (!is_read_q) begin
                dat_o = wr_word_q[idx];
            end
            if (len_q == LEN_W'(1)) begin
                cti_o = CTI_CLASSIC;
            end else if (last_word) begin
                cti_o = CTI_END;
            end else begin
                cti_o = CTI_INCR;
            end
        end
    end

    for (genvar g = 0; g < MAX_PAYLOAD; g++) begin : g_pout
        assign payload_out[g*DATA_WIDTH +: DATA_WIDTH] = rd_word_q[g];
    end

    assign busy       = (state_q != IDLE);
    assign completed  = completed_q;
    assign timeout    = timeout_q;
    assign error      = error_q;
    assign words_done = words_q;

endmodule

// File: tb/tb_wishbone_burst_master.sv
module tb_wishbone_burst_master;

    localparam int AW = 16, DW = 32, SW = 4, MP = 8, STEP = 4, MW = 15, LW = 4;
    localparam int VW = AW + DW + 3 + SW + 1;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [AW-1:0] adr_o, transfer_address;
    logic [DW-1:0] dat_i, dat_o;
    logic we_o, stb_o, cyc_o, cyc_i, ack_i, err_i;
    logic [SW-1:0] sel_o, byte_enable;
    logic [2:0] cti_o;
    logic [MP*DW-1:0] payload_in, payload_out;
    logic [LW-1:0] payload_length, words_done;
    logic start_read, start_write, abort, busy, completed, timeout, error;

    always #5 clk_i = ~clk_i;

    wishbone_burst_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .MAX_PAYLOAD(MP),
        .ADDR_STEP(STEP), .MAX_WAIT(MW), .LEN_W(LW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .adr_o(adr_o), .dat_i(dat_i), .dat_o(dat_o),
        .we_o(we_o), .sel_o(sel_o), .stb_o(stb_o), .cyc_o(cyc_o), .cyc_i(cyc_i),
        .ack_i(ack_i), .err_i(err_i), .cti_o(cti_o), .transfer_address(transfer_address),
        .payload_in(payload_in), .payload_out(payload_out), .payload_length(payload_length),
        .byte_enable(byte_enable), .start_read(start_read), .start_write(start_write),
        .abort(abort), .busy(busy), .completed(completed), .timeout(timeout),
        .error(error), .words_done(words_done)
    );

    int n_cmp = 0, n_err = 0;

    // slave behaviour for the next burst
    int cfg_busy;
    int cfg_wait [MP+1];
    int cfg_err, cfg_abort;

    // observations
    logic [DW-1:0] pay [MP];
    logic [DW-1:0] sdata [MP];
    logic [VW-1:0] log_v [128];
    int log_w [128];
    int log_n, cyc_n;
    bit obs_accept, obs_cyc_after;

    // reference model state
    logic [DW-1:0] exp_out [MP];
    logic [MP*DW-1:0] exp_pout;
    logic [VW-1:0] exp_v [MP];
    int exp_n, exp_wd;
    bit exp_done, exp_to, exp_er;

    task automatic cfg_clear();
        cfg_busy = 0; cfg_err = -1; cfg_abort = -1;
        for (int k = 0; k <= MP; k++) cfg_wait[k] = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cyc_i = 0; ack_i = 0; err_i = 0; abort = 0; dat_i = '0;
        start_read = 0; start_write = 0; transfer_address = '0;
        payload_in = '0; payload_length = '0; byte_enable = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int k = 0; k < MP; k++) exp_out[k] = '0;
    endtask

    // Drives one burst from a negedge and plays the slave; returns on the
    // negedge where busy is low again.
    task automatic run(input bit rd, input bit wr, input logic [AW-1:0] base,
                       input int len, input logic [SW-1:0] be);
        int sw, wl;
        bit hung;
        for (int k = 0; k < MP; k++) begin
            pay[k] = $urandom;
            payload_in[k*DW +: DW] = pay[k];
        end
        transfer_address = base; payload_length = LW'(len); byte_enable = be;
        start_read = rd; start_write = wr;
        log_n = 0; cyc_n = 0; sw = 0; wl = cfg_wait[0]; hung = 1;
        @(negedge clk_i);
        start_read = 0; start_write = 0;
        obs_accept = busy;
        for (int t = 1; t <= 300; t++) begin
            cyc_i = (t <= cfg_busy);
            ack_i = 0; err_i = 0; abort = 0; dat_i = $urandom;
            if (!busy) begin
                hung = 0;
                break;
            end
            if (cyc_o) cyc_n++;
            if (cyc_o && stb_o) begin
                if (log_n < 128) begin
                    log_v[log_n] = {adr_o, dat_o, cti_o, sel_o, we_o};
                    log_w[log_n] = sw;
                    log_n++;
                end
                if (cfg_abort == sw) abort = 1;
                else if (wl > 0) wl--;
                else begin
                    ack_i = 1; err_i = (cfg_err == sw);
                    if (sw < MP) sdata[sw] = dat_i;
                    sw++; wl = cfg_wait[(sw <= MP) ? sw : MP];
                end
            end
            @(negedge clk_i);
        end
        cyc_i = 0;
        obs_cyc_after = cyc_o;
        if (hung) begin
            n_cmp++; n_err++;
            $display("FAIL burst_bound: busy still %b after 300 cycles, required 0", busy);
            do_reset();
        end
    endtask

    // Expected outcome of a burst from the slave configuration alone.
    task automatic model(input bit rd, input logic [AW-1:0] base, input int len,
                         input logic [SW-1:0] be);
        int eff;
        bit stop;
        logic [DW-1:0] d;
        logic [2:0] c;
        eff = (len > MP) ? MP : len;
        exp_done = 0; exp_to = 0; exp_er = 0; exp_wd = 0; exp_n = 0; stop = 0;
        for (int k = 0; k < eff; k++) begin
            d = rd ? '0 : pay[k];
            c = (eff == 1) ? 3'b000 : ((k == eff - 1) ? 3'b111 : 3'b010);
            exp_v[k] = {base + AW'(k * STEP), d, c, be, ~rd};
        end
        if (eff == 0) exp_done = 1;
        else if (cfg_busy > MW) exp_to = 1;
        else begin
            for (int k = 0; k < eff && !stop; k++) begin
                if (cfg_abort == k) begin exp_n += 1; stop = 1; end
                else if (cfg_wait[k] > MW) begin exp_n += MW + 1; exp_to = 1; stop = 1; end
                else if (cfg_err == k) begin exp_n += cfg_wait[k] + 1; exp_er = 1; stop = 1; end
                else begin
                    exp_n += cfg_wait[k] + 1; exp_wd++;
                    if (rd) exp_out[k] = sdata[k];
                end
            end
            if (!stop) exp_done = 1;
        end
        for (int k = 0; k < MP; k++) exp_pout[k*DW +: DW] = exp_out[k];
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({cyc_o, stb_o, we_o, adr_o, sel_o, cti_o, dat_o} !== '0) begin
            n_err++;
            $display("FAIL reset_bus: cyc%b stb%b we%b adr%h sel%b cti%b dat%h, required all 0",
                     cyc_o, stb_o, we_o, adr_o, sel_o, cti_o, dat_o);
        end
        n_cmp++;
        if ({busy, completed, timeout, error, words_done} !== '0) begin
            n_err++;
            $display("FAIL reset_status: busy%b c%b t%b e%b wd%0d, required all 0",
                     busy, completed, timeout, error, words_done);
        end
        n_cmp++;
        if (payload_out !== '0) begin
            n_err++; $display("FAIL reset_payload: got %h, required 0", payload_out);
        end
    endtask

    task automatic test_read4();
        cfg_clear();
        run(1, 0, 16'h0100, 4, 4'hF);
        model(1, 16'h0100, 4, 4'hF);
        n_cmp++;
        if ({completed, timeout, error, words_done} !== {1'b1, 1'b0, 1'b0, LW'(4)}) begin
            n_err++; $display("FAIL read4_flags: got c%b t%b e%b wd%0d, required c1 t0 e0 wd4",
                              completed, timeout, error, words_done);
        end
        n_cmp++;
        if (cyc_n != 4 || log_n != 4) begin
            n_err++; $display("FAIL read4_cyc: got %0d/%0d cycles, required 4", cyc_n, log_n);
        end
        for (int i = 0; i < log_n && i < 4; i++) begin
            n_cmp++;
            if (log_v[i] !== exp_v[log_w[i]]) begin
                n_err++; $display("FAIL read4_beat%0d: got %h, required %h", i, log_v[i], exp_v[log_w[i]]);
            end
        end
        n_cmp++;
        if (payload_out !== exp_pout) begin
            n_err++; $display("FAIL read4_payload: got %h, required %h", payload_out, exp_pout);
        end
    endtask

    task automatic test_write_stall();
        cfg_clear();
        cfg_wait[1] = 2;
        run(0, 1, 16'h0010, 3, 4'b0011);
        model(0, 16'h0010, 3, 4'b0011);
        n_cmp++;
        if ({completed, timeout, error, words_done} !== {1'b1, 1'b0, 1'b0, LW'(3)}) begin
            n_err++; $display("FAIL wstall_flags: got c%b t%b e%b wd%0d, required c1 t0 e0 wd3",
                              completed, timeout, error, words_done);
        end
        n_cmp++;
        if (log_n != 5 || cyc_n != 5) begin
            n_err++; $display("FAIL wstall_len: got %0d/%0d cycles, required 5", log_n, cyc_n);
        end
        for (int i = 0; i < log_n && i < 5; i++) begin
            n_cmp++;
            if (log_v[i] !== exp_v[log_w[i]]) begin
                n_err++; $display("FAIL wstall_beat%0d: got %h, required %h", i, log_v[i], exp_v[log_w[i]]);
            end
        end
    endtask

    task automatic test_no_ack();
        cfg_clear();
        cfg_wait[0] = 1000;
        run(0, 1, 16'h0200, 3, 4'hF);
        n_cmp++;
        if ({completed, timeout, error, words_done} !== {1'b0, 1'b1, 1'b0, LW'(0)}) begin
            n_err++; $display("FAIL noack_flags: got c%b t%b e%b wd%0d, required c0 t1 e0 wd0",
                              completed, timeout, error, words_done);
        end
        n_cmp++;
        if (cyc_n != MW + 1 || obs_cyc_after !== 1'b0) begin
            n_err++; $display("FAIL noack_cyc: got %0d stalled cycles, cyc after %b, required %0d and 0",
                              cyc_n, obs_cyc_after, MW + 1);
        end
    endtask

    task automatic test_bus_busy();
        int holds [4] = '{20, 5, 15, 16};
        for (int j = 0; j < 4; j++) begin
            cfg_clear();
            cfg_busy = holds[j];
            run(0, 1, 16'h0300, 2, 4'hF);
            model(0, 16'h0300, 2, 4'hF);
            n_cmp++;
            if ({completed, timeout, error, words_done} !== {exp_done, exp_to, exp_er, LW'(exp_wd)}) begin
                n_err++; $display("FAIL busbusy%0d_flags: got c%b t%b e%b wd%0d, required c%b t%b e%b wd%0d",
                                  holds[j], completed, timeout, error, words_done, exp_done, exp_to, exp_er, exp_wd);
            end
            n_cmp++;
            if (cyc_n != exp_n) begin
                n_err++; $display("FAIL busbusy%0d_cyc: got %0d cycles, required %0d", holds[j], cyc_n, exp_n);
            end
        end
    endtask

    task automatic test_err_abort();
        for (int j = 0; j < 2; j++) begin
            cfg_clear();
            if (j == 0) cfg_err = 1; else cfg_abort = 2;
            run(1, 0, 16'h0400, (j == 0) ? 5 : 6, 4'hF);
            model(1, 16'h0400, (j == 0) ? 5 : 6, 4'hF);
            n_cmp++;
            if ({completed, timeout, error, words_done} !== {exp_done, exp_to, exp_er, LW'(exp_wd)}) begin
                n_err++; $display("FAIL errabort%0d_flags: got c%b t%b e%b wd%0d, required c%b t%b e%b wd%0d",
                                  j, completed, timeout, error, words_done, exp_done, exp_to, exp_er, exp_wd);
            end
            n_cmp++;
            if (cyc_n != exp_n || obs_cyc_after !== 1'b0) begin
                n_err++; $display("FAIL errabort%0d_cyc: got %0d cycles cyc after %b, required %0d and 0",
                                  j, cyc_n, obs_cyc_after, exp_n);
            end
            n_cmp++;
            if (payload_out !== exp_pout) begin
                n_err++; $display("FAIL errabort%0d_payload: got %h, required %h", j, payload_out, exp_pout);
            end
        end
    endtask

    task automatic test_len_edges();
        int lens [3] = '{0, 12, 3};
        for (int j = 0; j < 3; j++) begin
            cfg_clear();
            run(1, (j == 2), 16'hFFF8, lens[j], 4'b1010);
            model(1, 16'hFFF8, lens[j], 4'b1010);
            n_cmp++;
            if ({completed, timeout, error, words_done} !== {exp_done, exp_to, exp_er, LW'(exp_wd)}) begin
                n_err++; $display("FAIL len%0d_flags: got c%b t%b e%b wd%0d, required c%b t%b e%b wd%0d",
                                  lens[j], completed, timeout, error, words_done, exp_done, exp_to, exp_er, exp_wd);
            end
            n_cmp++;
            if (cyc_n != exp_n || log_n != exp_n) begin
                n_err++; $display("FAIL len%0d_cyc: got %0d cycles, required %0d", lens[j], cyc_n, exp_n);
            end
            for (int i = 0; i < log_n && i < exp_n; i++) begin
                n_cmp++;
                if (log_v[i] !== exp_v[log_w[i]]) begin
                    n_err++; $display("FAIL len%0d_beat%0d: got %h, required %h", lens[j], i, log_v[i], exp_v[log_w[i]]);
                end
            end
            n_cmp++;
            if (payload_out !== exp_pout) begin
                n_err++; $display("FAIL len%0d_payload: got %h, required %h", lens[j], payload_out, exp_pout);
            end
        end
    endtask

    task automatic test_back_to_back();
        cfg_clear();
        run(0, 1, 16'h0500, 2, 4'hF);
        n_cmp++;
        if (obs_cyc_after !== 1'b0 || completed !== 1'b1) begin
            n_err++; $display("FAIL b2b_first: cyc after %b completed %b, required 0 and 1", obs_cyc_after, completed);
        end
        run(1, 0, 16'h0600, 3, 4'hF);
        model(1, 16'h0600, 3, 4'hF);
        n_cmp++;
        if (obs_accept !== 1'b1) begin
            n_err++; $display("FAIL b2b_accept: busy after start %b, required 1", obs_accept);
        end
        n_cmp++;
        if ({completed, words_done} !== {1'b1, LW'(3)} || payload_out !== exp_pout) begin
            n_err++; $display("FAIL b2b_second: c%b wd%0d pout %h, required c1 wd3 pout %h",
                              completed, words_done, payload_out, exp_pout);
        end
    endtask

    task automatic test_random();
        bit rd;
        int len;
        logic [AW-1:0] base;
        logic [SW-1:0] be;
        for (int it = 0; it < 15; it++) begin
            cfg_clear();
            rd = 1'($urandom_range(0, 1));
            len = $urandom_range(1, MP);
            base = AW'($urandom);
            be = SW'($urandom);
            cfg_busy = $urandom_range(0, 4);
            for (int k = 0; k < MP; k++) cfg_wait[k] = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) cfg_err = $urandom_range(0, len - 1);
            else if ($urandom_range(0, 3) == 0) cfg_abort = $urandom_range(0, len - 1);
            run(rd, ~rd, base, len, be);
            model(rd, base, len, be);
            n_cmp++;
            if ({completed, timeout, error, words_done} !== {exp_done, exp_to, exp_er, LW'(exp_wd)}) begin
                n_err++; $display("FAIL rand%0d_flags: got c%b t%b e%b wd%0d, required c%b t%b e%b wd%0d",
                                  it, completed, timeout, error, words_done, exp_done, exp_to, exp_er, exp_wd);
            end
            n_cmp++;
            if (cyc_n != exp_n || log_n != exp_n) begin
                n_err++; $display("FAIL rand%0d_cyc: got %0d cycles, required %0d", it, cyc_n, exp_n);
            end
            for (int i = 0; i < log_n && i < exp_n; i++) begin
                n_cmp++;
                if (log_v[i] !== exp_v[log_w[i]]) begin
                    n_err++; $display("FAIL rand%0d_beat%0d: got %h, required %h", it, i, log_v[i], exp_v[log_w[i]]);
                end
            end
            n_cmp++;
            if (payload_out !== exp_pout) begin
                n_err++; $display("FAIL rand%0d_payload: got %h, required %h", it, payload_out, exp_pout);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        transfer_address = 16'h0700; payload_length = LW'(4); byte_enable = 4'hF;
        start_read = 1;
        @(negedge clk_i);
        start_read = 0; cyc_i = 0; seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (cyc_o) seen = 1;
            else @(negedge clk_i);
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL rstmid_start: cyc_o never rose within 10 cycles, required 1");
        end
        ack_i = 1; dat_i = $urandom;
        @(negedge clk_i);
        ack_i = 0;
        n_cmp++;
        if (words_done !== LW'(1) || cyc_o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: wd%0d cyc%b, required wd1 cyc1", words_done, cyc_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({cyc_o, stb_o, busy, words_done} !== '0 || payload_out !== '0) begin
            n_err++; $display("FAIL rstmid_drop: cyc%b stb%b busy%b wd%0d pout %h, required all 0",
                              cyc_o, stb_o, busy, words_done, payload_out);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int k = 0; k < MP; k++) exp_out[k] = '0;
    endtask

    initial begin
        test_reset();
        test_read4();
        test_write_stall();
        test_no_ack();
        test_bus_busy();
        test_err_abort();
        test_len_edges();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_read4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wishbone_burst_master.md
Name: wishbone_burst_master

Overview:
Parametrised Wishbone B4 classic burst master. Moves up to MAX_PAYLOAD words between a flat payload vector and a slave. Adds byte selects, a configurable address stride, err_i handling, abort, per-word stall timeout and a bus-free wait timeout. Sits between local control logic (SPI/USB command decoders, DMA-style engines) and the shared Wishbone interconnect.

Parameters:
ADDRESS_WIDTH, 16, width of adr_o and transfer_address
DATA_WIDTH, 32, word width; must be a multiple of 8
SEL_WIDTH, DATA_WIDTH/8, byte-select width
MAX_PAYLOAD, 8, maximum words per burst (1..64)
ADDR_STEP, 1, address increment per word
MAX_WAIT, 15, wait cycles allowed before a timeout (1..255)
LEN_W, $clog2(MAX_PAYLOAD+1), payload_length and words_done width (derived, not user-set)

Ports:
clk_i  in  1  clock; all logic is rising-edge
rst_ni  in  1  asynchronous active-low reset
adr_o  out  ADDRESS_WIDTH  word address
dat_i  in  DATA_WIDTH  read data
dat_o  out  DATA_WIDTH  write data; 0 when not writing
we_o  out  1  write enable
sel_o  out  SEL_WIDTH  byte selects
stb_o  out  1  strobe
cyc_o  out  1  cycle
cyc_i  in  1  another master owns the bus
ack_i  in  1  slave acknowledge
err_i  in  1  slave error
cti_o  out  3  cycle type identifier
transfer_address  in  ADDRESS_WIDTH  base address
payload_in  in  MAX_PAYLOAD*DATA_WIDTH  write words; word k is at bits [k*DATA_WIDTH +: DATA_WIDTH]
payload_out  out  MAX_PAYLOAD*DATA_WIDTH  read words, same packing
payload_length  in  LEN_W  number of words
byte_enable  in  SEL_WIDTH  sel_o value for the whole burst
start_read  in  1  start a read (single-cycle pulse or level)
start_write  in  1  start a write
abort  in  1  terminate the current burst
busy  out  1  not in IDLE
completed  out  1  sticky: last burst finished
timeout  out  1  sticky: last burst timed out
error  out  1  sticky: last burst received err_i
words_done  out  LEN_W  words acknowledged in the current or last burst

Behaviour:
- Reset (rst_ni low, takes effect immediately): state IDLE; every output 0, including payload_out and words_done.
- Outputs cyc_o, stb_o, we_o, adr_o, sel_o, cti_o and dat_o are combinational from state and registers. No input-to-output combinational path.
- Start acceptance, IDLE only:
  - start_read takes priority over start_write.
  - On accept, latch transfer_address, byte_enable and payload_in, plus the effective length: min(payload_length, MAX_PAYLOAD).
  - Clear completed, timeout, error and words_done. Load the wait counter with MAX_WAIT.
  - Effective length 0: go straight back to IDLE and set completed the next cycle. No bus activity.
  - Otherwise go to WAIT_BUS.
- Start inputs are ignored outside IDLE. Latched data is stable for the whole burst.
- WAIT_BUS:
  - cyc_i low: go to XFER next cycle and reload the counter.
  - cyc_i high: decrement the counter. If the counter is 0 and cyc_i is still high, set timeout and go to IDLE.
- XFER drives:
  - cyc_o=1, stb_o=1, we_o=write, sel_o=latched byte_enable.
  - adr_o = base + offset*ADDR_STEP, truncated to ADDRESS_WIDTH (wraps).
  - dat_o = payload word[offset].
  - cti_o = 000 if length==1; otherwise 010, and 111 on the last word.
- XFER, each cycle, in priority order:
  1. abort: go to IDLE; no flag set; words_done holds.
  2. err_i: set error and go to IDLE. err_i beats a simultaneous ack_i.
  3. ack_i: on a read, capture dat_i into word[offset]. Increment offset and words_done, reload the counter. If this was the last word, set completed and go to IDLE; cyc_o falls on the next cycle.
  4. No ack: decrement the counter. At 0, set timeout and go to IDLE.
- Back-to-back: a start asserted in the cycle after returning to IDLE is accepted. Minimum turnaround is 1 idle cycle with cyc_o low.
- payload_out words not written by the current read keep their previous values.

Decomposition:
- Package wb_master_pkg:
  - CTI constants: CTI_CLASSIC=000, CTI_INCR=010, CTI_END=111.
  - State enum: IDLE, WAIT_BUS, XFER, DONE0. DONE0 is used only for the zero-length completion.
- Sub-module wb_wait_timer:
  - Inputs: load, dec. Output: expired.
  - Parametrised on MAX_WAIT; instantiated once and shared by WAIT_BUS and XFER.

Test Plan:
- 4-word read at 0x0100, slave acks every cycle, DATA_WIDTH 32 -> adr_o 0x0100..0x0103, cti_o 010,010,010,111, payload_out holds the slave data, completed=1, words_done=4, cyc_o high for exactly 4 cycles.
- 3-word write, ADDR_STEP=4, byte_enable=0011, slave inserts 2 wait states on word 1 -> adr_o 0x10/0x14/0x18, sel_o=0011 throughout, dat_o stable across the stall, completed=1.
- Slave never acks, MAX_WAIT=15 -> timeout=1 after 16 stalled cycles, cyc_o low the next cycle, completed=0, words_done=0.
- cyc_i held high for 20 cycles after start_write -> timeout=1 with no cyc_o assertion. Repeat with cyc_i released after 5 cycles -> burst proceeds.
- err_i and ack_i together on word 2 of 5 -> error=1, words_done=1, cyc_o drops. Abort on word 3 of 6 -> no flags set, words_done=2.
- Length 0, length > MAX_PAYLOAD (clamped), start_read with start_write (read wins), and rst_ni low mid-burst (cyc_o/stb_o drop to 0 without waiting for a clock edge).
